// File: rtl/leb128_reader_pkg.sv
// Shared definitions for the LEB128 reader.
//   - Error codes reported on error_code.
//   - Maximum encoded length of a 32-bit LEB128 value.
//   - FSM state encoding.
package leb128_reader_pkg;

    localparam logic [1:0] LEB_ERR_NONE     = 2'd0;
    localparam logic [1:0] LEB_ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] LEB_ERR_TOO_LONG = 2'd2;
    localparam logic [1:0] LEB_ERR_OVERFLOW = 2'd3;

    localparam int LEB_MAX_BYTES = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } leb_state_t;

endpackage

// File: rtl/leb128_reader.sv
// LEB128 reader: fetches one uleb32/sleb32 value from a byte-wide ROM port
// and reports the decoded value, its encoded length and the next address.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle decode request (sampled only when idle)
//   start_addr      address of the first encoded byte
//   signed_mode     0 = uleb32, 1 = sleb32 (sampled with start)
//   busy            decode in progress
//   done / error    one-cycle completion / abort pulses
//   error_code      0 none, 1 timeout, 2 too long, 3 overflow
//   value, length   decoded value and bytes consumed
//   next_addr       start_addr + length
//   rom_addr, rom_read_en, rom_data, rom_ready   ROM read handshake
module leb128_reader
    import leb128_reader_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic        signed_mode,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code,
    output logic [31:0] value,
    output logic [2:0]  length,
    output logic [31:0] next_addr,
    output logic [31:0] rom_addr,
    output logic        rom_read_en,
    input  logic [7:0]  rom_data,
    input  logic        rom_ready
);

    localparam int TW = $clog2(TIMEOUT + 1);

    leb_state_t  state_reg, state_next;
    logic [31:0] base_reg, base_next;
    logic        signed_reg, signed_next;
    logic        fail_reg, fail_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        error_reg, error_next;
    logic [1:0]  error_code_reg, error_code_next;
    logic [31:0] value_reg, value_next;
    logic [2:0]  length_reg, length_next;
    logic [31:0] next_addr_reg, next_addr_next;
    logic [31:0] rom_addr_reg, rom_addr_next;
    logic        rom_read_en_reg, rom_read_en_next;

    // Datapath for the byte being captured (n = length_reg).
    logic [4:0]  shamt;
    logic [4:0]  sign_pos;
    logic [31:0] merged;
    logic [31:0] ext_mask;
    logic        last_slot;
    logic        byte5_bad;

    always_comb begin
        shamt     = 5'(length_reg) * 5'd7;
        sign_pos  = shamt + 5'd6;
        // Shifting into 32 bits drops payload bits above bit 31 of byte 5.
        merged    = value_reg | (32'(rom_data[6:0]) << shamt);
        ext_mask  = 32'hFFFF_FFFF << (sign_pos + 5'd1);
        last_slot = (length_reg == 3'(LEB_MAX_BYTES - 1));
        // Byte 5 carries bits 28..34; bits 32..34 must be zero (unsigned)
        // or copies of bit 31 (signed) for the value to fit in 32 bits.
        byte5_bad = signed_reg ? (rom_data[6:4] != {3{rom_data[3]}})
                               : (rom_data[6:4] != 3'b000);
    end

    always_comb begin
        state_next       = state_reg;
        base_next        = base_reg;
        signed_next      = signed_reg;
        fail_next        = fail_reg;
        timer_next       = timer_reg;
        busy_next        = busy_reg;
        done_next        = 1'b0;
        error_next       = 1'b0;
        error_code_next  = error_code_reg;
        value_next       = value_reg;
        length_next      = length_reg;
        next_addr_next   = next_addr_reg;
        rom_addr_next    = rom_addr_reg;
        rom_read_en_next = rom_read_en_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    base_next        = start_addr;
                    signed_next      = signed_mode;
                    fail_next        = 1'b0;
                    timer_next       = '0;
                    busy_next        = 1'b1;
                    error_code_next  = LEB_ERR_NONE;
                    value_next       = '0;
                    length_next      = '0;
                    rom_addr_next    = start_addr;
                    rom_read_en_next = 1'b1;
                    state_next       = ST_REQ;
                end
            end

            ST_REQ: begin
                if (rom_ready) begin
                    value_next    = merged;
                    length_next   = length_reg + 3'd1;
                    rom_addr_next = rom_addr_reg + 32'd1;
                    timer_next    = '0;
                    if (rom_data[7]) begin
                        if (last_slot) begin
                            fail_next        = 1'b1;
                            error_code_next  = LEB_ERR_TOO_LONG;
                            rom_read_en_next = 1'b0;
                            state_next       = ST_DONE;
                        end
                        // Otherwise keep requesting: the new address is the
                        // next request.
                    end else begin
                        // Drop the request now so the incremented address is
                        // never presented as a live read.
                        rom_read_en_next = 1'b0;
                        next_addr_next   = base_reg + 32'(length_reg) + 32'd1;
                        state_next       = ST_DONE;
                        if (last_slot) begin
                            if (byte5_bad) begin
                                fail_next       = 1'b1;
                                error_code_next = LEB_ERR_OVERFLOW;
                            end
                        end else if (signed_reg && merged[sign_pos]) begin
                            value_next = merged | ext_mask;
                        end
                    end
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    fail_next        = 1'b1;
                    error_code_next  = LEB_ERR_TIMEOUT;
                    rom_read_en_next = 1'b0;
                    state_next       = ST_DONE;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            ST_DONE: begin
                busy_next        = 1'b0;
                rom_read_en_next = 1'b0;
                done_next        = !fail_reg;
                error_next       = fail_reg;
                state_next       = ST_IDLE;
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            base_reg        <= '0;
            signed_reg      <= 1'b0;
            fail_reg        <= 1'b0;
            timer_reg       <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            error_code_reg  <= LEB_ERR_NONE;
            value_reg       <= '0;
            length_reg      <= '0;
            next_addr_reg   <= '0;
            rom_addr_reg    <= '0;
            rom_read_en_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            base_reg        <= base_next;
            signed_reg      <= signed_next;
            fail_reg        <= fail_next;
            timer_reg       <= timer_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            error_reg       <= error_next;
            error_code_reg  <= error_code_next;
            value_reg       <= value_next;
            length_reg      <= length_next;
            next_addr_reg   <= next_addr_next;
            rom_addr_reg    <= rom_addr_next;
            rom_read_en_reg <= rom_read_en_next;
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign error       = error_reg;
    assign error_code  = error_code_reg;
    assign value       = value_reg;
    assign length      = length_reg;
    assign next_addr   = next_addr_reg;
    assign rom_addr    = rom_addr_reg;
    assign rom_read_en = rom_read_en_reg;

endmodule

// File: tb/tb_leb128_reader.sv
// Testbench for leb128_reader: ROM responder model, arithmetic LEB128
// reference model, scoreboard queue checked by an independent monitor.
module tb_leb128_reader;
    import leb128_reader_pkg::*;

    localparam int TIMEOUT  = 64;
    localparam int MEM_SIZE = 4096;

    typedef logic [7:0] bytes_t [$];
    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [31:0] value;
        logic [2:0]  len;
        logic [31:0] next;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_addr = 32'd0;
    logic        signed_mode = 1'b0;
    logic        busy, done, error;
    logic [1:0]  error_code;
    logic [31:0] value, next_addr, rom_addr;
    logic [2:0]  length;
    logic        rom_read_en;
    logic [7:0]  rom_data = 8'h00;
    logic        rom_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int strobes = 0;
    int txn = 0;

    logic [7:0]  mem [0:MEM_SIZE-1];
    exp_t        sb[$];
    exp_t        mon_e;
    int          rom_wait = 0;
    bit          rom_mute = 1'b0;
    bit          stab_en = 1'b0;
    logic [31:0] last_served = 32'hFFFF_FFFF;
    bit          served_valid = 1'b0;
    int          wait_cnt = 0;
    int          next_free = 'h20;

    leb128_reader #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .signed_mode(signed_mode), .busy(busy), .done(done), .error(error),
        .error_code(error_code), .value(value), .length(length),
        .next_addr(next_addr), .rom_addr(rom_addr), .rom_read_en(rom_read_en),
        .rom_data(rom_data), .rom_ready(rom_ready)
    );

    always #5 clk = ~clk;

    // ROM responder: registered data, one-cycle ready strobe, serves an
    // address only if it differs from the last one served.
    always @(posedge clk) begin
        if (rom_ready) strobes++;
        rom_ready <= 1'b0;
        if (!rom_read_en || rom_mute) begin
            wait_cnt = 0;
        end else if (!rom_ready && !(served_valid && rom_addr == last_served)) begin
            if (wait_cnt < rom_wait) begin
                wait_cnt++;
            end else begin
                rom_ready    <= 1'b1;
                rom_data     <= mem[rom_addr[11:0]];
                last_served  <= rom_addr;
                served_valid <= 1'b1;
                wait_cnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the byte list.
    function automatic exp_t model(input logic [31:0] addr, input bit sgn, input bytes_t b);
        exp_t   e;
        longint acc;
        longint digit;
        int     n;
        logic [7:0] x;
        e.is_err = 1'b0; e.code = LEB_ERR_NONE; e.value = '0; e.len = '0; e.next = '0;
        acc = 0;
        n = 0;
        for (int i = 0; i < b.size(); i++) begin
            x = b[i];
            digit = x[6:0];
            acc += digit << (7 * i);
            n = i + 1;
            if (!x[7]) break;
            if (n == LEB_MAX_BYTES) begin
                e.is_err = 1'b1;
                e.code   = LEB_ERR_TOO_LONG;
                return e;
            end
        end
        x = b[n-1];
        if (sgn) begin
            if (x[6]) acc -= longint'(1) << (7 * n);
            if (acc < -(longint'(1) << 31) || acc >= (longint'(1) << 31)) begin
                e.is_err = 1'b1;
                e.code   = LEB_ERR_OVERFLOW;
                return e;
            end
        end else if (acc >= (longint'(1) << 32)) begin
            e.is_err = 1'b1;
            e.code   = LEB_ERR_OVERFLOW;
            return e;
        end
        e.value = acc[31:0];
        e.len   = 3'(n);
        e.next  = addr + 32'(n);
        return e;
    endfunction

    function automatic logic [31:0] alloc(input int n);
        int a;
        a = next_free + int'($urandom_range(0, 3));
        next_free = a + n + 1;
        return 32'(a);
    endfunction

    function automatic bytes_t gen_bytes();
        bytes_t     b;
        logic [7:0] x;
        int         l, nb;
        l  = int'($urandom_range(1, 6));
        nb = (l == 6) ? 5 : l;
        for (int i = 0; i < nb; i++) begin
            x = 8'($urandom);
            x[7] = (i < nb - 1) || (l == 6);
            b.push_back(x);
        end
        return b;
    endfunction

    // Scoreboard monitor: every done/error pulse pops one expectation.
    always @(negedge clk) begin
        if (!rst && (done === 1'b1 || error === 1'b1)) begin
            txn++;
            $display("txn %0d: done=%0b error=%0b code=%0d value=0x%08h length=%0d next_addr=0x%08h",
                     txn, done, error, error_code, value, length, next_addr);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got done=%0b error=%0b, expected no pulse", done, error);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind", {31'b0, error}, {31'b0, mon_e.is_err});
                chk("pulse_exclusive", {31'b0, done & error}, 32'd0);
                chk("busy_on_pulse", {31'b0, busy}, 32'd0);
                chk("read_en_on_pulse", {31'b0, rom_read_en}, 32'd0);
                chk("error_code", {30'b0, error_code}, {30'b0, mon_e.code});
                if (!mon_e.is_err) begin
                    chk("value", value, mon_e.value);
                    chk("length", {29'b0, length}, {29'b0, mon_e.len});
                    chk("next_addr", next_addr, mon_e.next);
                end
            end
        end
    end

    // Address / read_en must hold while a request waits for ready.
    logic [31:0] addr_prev = '0;
    logic        en_prev = 1'b0;
    logic        rdy_prev = 1'b1;
    always @(negedge clk) begin
        if (stab_en && !rst && en_prev && !rdy_prev) begin
            chk("addr_stable", rom_addr, addr_prev);
            chk("read_en_stable", {31'b0, rom_read_en}, 32'd1);
        end
        addr_prev = rom_addr;
        en_prev   = rom_read_en;
        rdy_prev  = rom_ready;
    end

    task automatic run_decode(input logic [31:0] addr, input bit sgn, input bytes_t b,
                              input exp_t e, input int exp_strobes, output int lat);
        int s0;
        for (int i = 0; i < b.size(); i++) mem[(int'(addr) + i) % MEM_SIZE] = b[i];
        sb.push_back(e);
        s0 = strobes;
        @(negedge clk);
        start = 1'b1; start_addr = addr; signed_mode = sgn;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && error !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 400) begin
            checks++;
            errors++;
            $display("FAIL no_pulse: got no done/error within %0d cycles, expected one", lat);
            if (sb.size() > 0) sb.delete(sb.size() - 1);
        end
        repeat (3) @(negedge clk);
        chk("rom_strobes", 32'(strobes - s0), 32'(exp_strobes));
    endtask

    task automatic directed(input bit sgn, input bytes_t b);
        logic [31:0] a;
        int lat;
        a = alloc(b.size());
        run_decode(a, sgn, b, model(a, sgn, b), b.size(), lat);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] a, other;
        bytes_t      b;
        exp_t        e;
        bit          s;

        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_error_code", {30'b0, error_code}, 32'd0);
        chk("rst_value", value, 32'd0);
        chk("rst_length", {29'b0, length}, 32'd0);
        chk("rst_next_addr", next_addr, 32'd0);
        chk("rst_rom_addr", rom_addr, 32'd0);
        chk("rst_rom_read_en", {31'b0, rom_read_en}, 32'd0);

        stab_en = 1'b1;
        b = '{8'hE5, 8'h8E, 8'h26};
        run_decode(32'h10, 1'b0, b, model(32'h10, 1'b0, b), 3, lat);
        chk("latency_3byte", 32'(lat), 32'd7);
        chk("value_98765", value, 32'h0009_8765);
        chk("next_addr_13", next_addr, 32'h13);

        directed(1'b1, '{8'hC0, 8'hBB, 8'h78});
        chk("sleb_neg_value", value, 32'hFFFE_1DC0);
        directed(1'b1, '{8'h7F});
        directed(1'b0, '{8'h7F});
        directed(1'b0, '{8'h08});
        directed(1'b0, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F});
        directed(1'b0, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F});
        directed(1'b0, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
        directed(1'b1, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F});
        directed(1'b1, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h4F});

        // Silent ROM: decode must abort with a timeout.
        rom_mute = 1'b1;
        stab_en  = 1'b0;
        a = alloc(1);
        b = '{8'h01};
        e.is_err = 1'b1; e.code = LEB_ERR_TIMEOUT; e.value = '0; e.len = '0; e.next = '0;
        run_decode(a, 1'b0, b, e, 0, lat);
        checks++;
        if (lat < TIMEOUT || lat > TIMEOUT + 2) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles, expected %0d..%0d", lat, TIMEOUT, TIMEOUT + 2);
        end
        rom_mute = 1'b0;
        stab_en  = 1'b1;

        // Wait states on every byte.
        rom_wait = 3;
        directed(1'b0, '{8'hE5, 8'h8E, 8'h26});
        chk("wait_value_98765", value, 32'h0009_8765);
        rom_wait = 0;

        // Reset while waiting on byte 2.
        stab_en = 1'b0;
        a = alloc(3);
        mem[a[11:0]] = 8'h80; mem[a[11:0] + 12'd1] = 8'h80; mem[a[11:0] + 12'd2] = 8'h01;
        @(negedge clk);
        start = 1'b1; start_addr = a; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (rom_ready !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("rst_test_first_strobe", {31'b0, rom_ready}, 32'd1);
        @(negedge clk);
        chk("rst_test_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_read_en", {31'b0, rom_read_en}, 32'd0);
        chk("midrst_value", value, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        stab_en = 1'b1;

        // start while busy is ignored.
        a = alloc(3);
        b = '{8'hE5, 8'h8E, 8'h26};
        for (int i = 0; i < 3; i++) mem[(int'(a) + i) % MEM_SIZE] = b[i];
        other = alloc(1);
        mem[other[11:0]] = 8'h05;
        sb.push_back(model(a, 1'b0, b));
        @(negedge clk);
        start = 1'b1; start_addr = a; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; start_addr = other; signed_mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && error !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        repeat (10) @(negedge clk);
        chk("ignored_start_drained", 32'(sb.size()), 32'd0);
        chk("ignored_start_value", value, 32'h0009_8765);

        // Randomized decodes against the reference model.
        for (int t = 0; t < 120; t++) begin
            b = gen_bytes();
            s = 1'($urandom_range(0, 1));
            rom_wait = int'($urandom_range(0, 3));
            a = alloc(b.size());
            run_decode(a, s, b, model(a, s, b), b.size(), lat);
        end
        rom_wait = 0;

        repeat (5) @(negedge clk);
        chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leb128_reader.md
Name: leb128_reader

Overview:
- Initiator side of the byte-wide ROM read handshake (addr / read_en / data / ready).
- Fetches one LEB128-encoded integer (unsigned or signed, max 32-bit) starting at a given byte address, decodes it, and reports value, encoded length and next address.
- Used by the wasm loader for section sizes, indices and immediates; sits between loader control and the ROM port.

Parameters:
- TIMEOUT, 64, cycles to wait for rom_ready per byte before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to decode; sampled only in IDLE
- start_addr  in  32  byte address of first LEB byte
- signed_mode  in  1  0 = uleb32, 1 = sleb32; sampled with start
- busy  out  1  high from cycle after start until done/error
- done  out  1  one-cycle pulse, result valid
- error  out  1  one-cycle pulse, decode aborted
- error_code  out  2  0 none, 1 timeout, 2 too long, 3 overflow; held until next start
- value  out  32  decoded value; held until next start
- length  out  3  bytes consumed (1..5)
- next_addr  out  32  start_addr + length
- rom_addr  out  32  byte address to ROM
- rom_read_en  out  1  read request
- rom_data  in  8  ROM byte
- rom_ready  in  1  ROM data valid strobe

Behaviour:
- All outputs registered. Reset values: busy 0, done 0, error 0, error_code 0, value 0, length 0, next_addr 0, rom_addr 0, rom_read_en 0. Same values on reset mid-decode; the next cycle is IDLE.
- States: IDLE, REQ, DONE.
- IDLE:
  - start=1 -> latch start_addr/signed_mode.
  - Clear value, length and error_code.
  - Drive rom_addr=start_addr, rom_read_en=1, busy=1; go to REQ.
  - start while busy is ignored.
- REQ:
  - Hold rom_addr and rom_read_en stable until rom_ready=1.
  - On the edge sampling rom_ready=1, capture rom_data as byte n (n = length):
    - OR rom_data[6:0] into value at bit 7n (bits above 31 discarded).
    - length++, rom_addr++.
  - If rom_data[7]=1 and n<4 -> stay in REQ for the next byte. rom_read_en stays high; the address change is the new request.
  - If rom_data[7]=1 and n=4 -> error, code 2 (too long).
  - If rom_data[7]=0 -> finish:
    - signed_mode: sign-extend from bit 7(n+1)-1 when n<4.
    - next_addr = start_addr + length.
    - Go to DONE.
- Byte 5 checks (n=4, rom_data[7]=0):
  - unsigned: rom_data[6:4] must be 000.
  - signed: rom_data[6:4] must equal {3{rom_data[3]}}.
  - Violation -> error, code 3 (overflow).
- DONE: pulse done for 1 cycle, busy=0, rom_read_en=0; return to IDLE.
- Error path:
  - Pulse error for 1 cycle, busy=0, rom_read_en=0.
  - value, length and next_addr are undefined but held.
  - Return to IDLE.
- Timeout:
  - Per-byte counter reloads on every request.
  - If TIMEOUT cycles pass in REQ with no rom_ready -> error, code 1.
- Responder contract:
  - Data registered; ready is a 1-cycle strobe, at the earliest the edge after the request is seen.
  - The responder answers only when the address differs from its previous served address.
  - Consequence: re-decoding at the address of the last byte previously served times out. Callers advance addresses monotonically.
- Latency with a zero-wait responder:
  - 2 cycles per byte (request edge, ready edge).
  - done asserts 2·length+1 cycles after the start edge.
- rom_ready in IDLE/DONE is ignored.
- start on the same edge as a done pulse is not sampled; accepted from the following IDLE cycle.

Decomposition:
- Error-code constants LEB_ERR_NONE/TIMEOUT/TOO_LONG/OVERFLOW and LEB_MAX_BYTES=5 go in src/platform.v, alongside the existing shared constants.
- Single module. No sub-module; the shift/sign-extend datapath is small enough to stay inline.

Test Plan:
- uleb, ROM[0x10..0x12]=E5 8E 26, start_addr=0x10 -> done with value=0x00098765, length=3, next_addr=0x13. Zero-wait ROM gives done 7 cycles after start. Exactly 3 rom_ready strobes consumed.
- sleb, bytes C0 BB 78 -> value=0xFFFE1DC0 (-123456), length=3. Single byte: 7F -> 0xFFFFFFFF (signed), 0x0000007F (unsigned). Byte 08 unsigned -> 0x8, length=1.
- uleb FF FF FF FF 0F -> 0xFFFFFFFF, length=5:
  - FF FF FF FF 1F -> error code 3.
  - FF FF FF FF FF -> error code 2, rom_read_en low next cycle.
  - sleb FF FF FF FF 7F -> 0xFFFFFFFF.
  - sleb FF FF FF FF 4F -> error code 3.
- Responder never raises ready (TIMEOUT=64) -> error code 1 exactly 64 cycles into REQ; busy falls, rom_read_en falls.
- Responder with 3-cycle wait states per byte -> rom_addr and rom_read_en stable during each wait; uleb E5 8E 26 still yields 0x98765.
- rst asserted while waiting on byte 2 -> next cycle busy=0, rom_read_en=0, done/error never pulse. start pulsed while busy -> ignored; value unchanged.
